// File: rtl/srl_dly_pkg.sv
// Shared types and helpers for the SRL delay-chain controller.
// The SRL depth is fixed at 16 taps per stage.
package srl_dly_pkg;

    localparam int unsigned SRL_DEPTH = 16;
    localparam int unsigned SRL_AW    = 4;

    typedef enum logic [0:0] {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } srl_dly_state_e;

    // STG_SEL width; kept at least 1 bit so a single-stage chain still has a port.
    function automatic int unsigned stg_width(input int unsigned nstg);
        return (nstg > 1) ? $clog2(nstg) : 1;
    endfunction

    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned maxd);
        if (dly == 0) begin
            return 1;
        end
        if (dly > maxd) begin
            return maxd;
        end
        return dly;
    endfunction

endpackage

// File: rtl/srl_dly_cnt.sv
// Flush counter: counts enabled cycles from 0 and flags the cycle whose
// increment reaches the terminal value.
module srl_dly_cnt #(
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [DW-1:0] i_term,
    output logic          o_term
);

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + DW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign o_term = i_en & (w_cnt_inc == i_term);

endmodule

// File: rtl/srl_dly_ctrl.sv
// Sequencer/configurator for a cascade of 16-deep SRL stages; flushes stale data
// on every (re)load. Optional dropped-sample counter behind SRLDC_DROP_CNT_EN.
module srl_dly_ctrl
    import srl_dly_pkg::*;
#(
    parameter int unsigned NSTG    = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned DEF_DLY = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DW-1:0]                DLY,
    input  logic                         LD,
    input  logic                         PAUSE,
    input  logic                         DIN,
    input  logic [NSTG-1:0]              SRL_O,
    output logic                         SRL_I,
    output logic                         SRL_CE,
    output logic [SRL_AW-1:0]            SRL_A,
    output logic [stg_width(NSTG)-1:0]   STG_SEL,
    output logic [DW-1:0]                CUR_DLY,
    output logic                         BUSY,
    output logic                         VLD,
    output logic                         DOUT
`ifdef SRLDC_DROP_CNT_EN
    ,
    output logic [7:0]                   DROP_CNT
`endif
);

    localparam int unsigned   MAXD    = NSTG * SRL_DEPTH;
    localparam int unsigned   SW      = stg_width(NSTG);
    localparam logic [DW-1:0] DEF_D   = DW'(clamp_dly(DEF_DLY, MAXD));
    localparam logic [DW-1:0] DEF_DM1 = DEF_D - DW'(1);

    srl_dly_state_e    r_state;
    logic [DW-1:0]     r_cur_dly;
    logic [SRL_AW-1:0] r_srl_a;
    logic [SW-1:0]     r_stg_sel;
    logic              r_dout;

    logic [DW-1:0]     w_ld_dly;
    logic [DW-1:0]     w_ld_dm1;
    logic              w_run;
    logic              w_flush;
    logic              w_cnt_en;
    logic              w_term;
    logic              w_done;

    assign w_ld_dly = DW'(clamp_dly(32'(DLY), MAXD));
    assign w_ld_dm1 = w_ld_dly - DW'(1);
    assign w_run    = (r_state == RUN);
    assign w_flush  = (r_state == FLUSH);
    assign w_cnt_en = w_flush & ~PAUSE;
    // A load on the terminal cycle restarts the flush instead of finishing it.
    assign w_done   = w_term & ~LD;

    srl_dly_cnt #(
        .DW(DW)
    ) u_cnt (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_en   (w_cnt_en),
        .i_clr  (LD),
        .i_term (r_cur_dly),
        .o_term (w_term)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= FLUSH;
            r_cur_dly <= DEF_D;
            r_srl_a   <= DEF_DM1[SRL_AW-1:0];
            r_stg_sel <= SW'(DEF_DM1 >> SRL_AW);
            r_dout    <= 1'b0;
        end else begin
            if (LD) begin
                r_state   <= FLUSH;
                r_cur_dly <= w_ld_dly;
                r_srl_a   <= w_ld_dm1[SRL_AW-1:0];
                r_stg_sel <= SW'(w_ld_dm1 >> SRL_AW);
            end else if (w_done) begin
                r_state <= RUN;
            end
            if (SRL_CE) begin
                r_dout <= VLD & SRL_O[r_stg_sel];
            end
        end
    end

    // Zeros are shifted in while flushing so stale taps are overwritten.
    assign SRL_I   = w_run & DIN;
    assign SRL_CE  = ~PAUSE & ~RST;
    assign SRL_A   = r_srl_a;
    assign STG_SEL = r_stg_sel;
    assign CUR_DLY = r_cur_dly;
    assign BUSY    = w_flush | RST;
    assign VLD     = w_run & ~RST;
    assign DOUT    = r_dout;

`ifdef SRLDC_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop = DIN & (w_flush | PAUSE);

    always_ff @(posedge CLK) begin
        if (RST || LD) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign DROP_CNT = r_drop_cnt;
`endif

endmodule

// File: tb/tb_srl_dly_ctrl.sv
// Bench for srl_dly_ctrl with a behavioural SRL chain and a DOUT pulse scoreboard.
module tb_srl_dly_ctrl;

    localparam int unsigned NSTG    = 8;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEF_DLY = 64;
    localparam int unsigned MAXD    = NSTG * 16;

    logic            CLK   = 1'b0;
    logic            RST   = 1'b1;
    logic            LD    = 1'b0;
    logic            PAUSE = 1'b0;
    logic            DIN   = 1'b0;
    logic [DW-1:0]   DLY   = '0;
    logic [NSTG-1:0] SRL_O;
    logic            SRL_I;
    logic            SRL_CE;
    logic [3:0]      SRL_A;
    logic [2:0]      STG_SEL;
    logic [DW-1:0]   CUR_DLY;
    logic            BUSY;
    logic            VLD;
    logic            DOUT;
`ifdef SRLDC_DROP_CNT_EN
    logic [7:0]      DROP_CNT;
`endif

    // Chain starts full of ones so any stale exposure shows up on DOUT.
    logic [MAXD-1:0] chain = '1;
    int              ecnt  = 0;
    int              n_chk = 0;
    int              n_err = 0;
    int              q[$];
    bit              mon_en = 1'b0;

    srl_dly_ctrl #(
        .NSTG    (NSTG),
        .DW      (DW),
        .DEF_DLY (DEF_DLY)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DLY      (DLY),
        .LD       (LD),
        .PAUSE    (PAUSE),
        .DIN      (DIN),
        .SRL_O    (SRL_O),
        .SRL_I    (SRL_I),
        .SRL_CE   (SRL_CE),
        .SRL_A    (SRL_A),
        .STG_SEL  (STG_SEL),
        .CUR_DLY  (CUR_DLY),
        .BUSY     (BUSY),
        .VLD      (VLD),
        .DOUT     (DOUT)
`ifdef SRLDC_DROP_CNT_EN
        ,
        .DROP_CNT (DROP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ecnt <= ecnt + 1;

    always @(posedge CLK) begin
        if (SRL_CE === 1'b1) begin
            chain <= {chain[MAXD-2:0], SRL_I};
        end
    end

    always_comb begin
        SRL_O = '0;
        for (int s = 0; s < NSTG; s++) begin
            SRL_O[s] = chain[s*16 + int'(SRL_A)];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ld(input int dly);
        DLY = DW'(dly);
        LD  = 1'b1;
        step();
        LD  = 1'b0;
    endtask

    task automatic wait_vld(input string name, input int exp);
        int n = 0;
        while (VLD !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk(name, n, exp);
    endtask

    // One-cycle DIN pulse, expected on DOUT after edge (sample edge + d).
    task automatic pulse(input int d);
        DIN = 1'b1;
        q.push_back(ecnt + 1 + d);
        step();
        DIN = 1'b0;
    endtask

    task automatic monitor();
        bit exp_b;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                exp_b = 1'b0;
                while (q.size() > 0 && q[0] < ecnt) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missed_pulse: due edge %0d still pending at edge %0d", q[0], ecnt);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0] == ecnt) begin
                    exp_b = 1'b1;
                    void'(q.pop_front());
                end
                n_chk++;
                if (DOUT !== exp_b) begin
                    n_err++;
                    $display("FAIL dout@edge%0d: got %b expected %b", ecnt, DOUT, exp_b);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        int celow;
        fork
            monitor();
        join_none

        idle(2);
        chk("rst_vld", int'(VLD), 0);
        chk("rst_busy", int'(BUSY), 1);
        chk("rst_ce", int'(SRL_CE), 0);
        chk("rst_cur", int'(CUR_DLY), 64);
        chk("rst_a", int'(SRL_A), 15);
        chk("rst_stg", int'(STG_SEL), 3);
        chk("rst_dout", int'(DOUT), 0);
        mon_en = 1'b1;
        RST = 1'b0;
        wait_vld("def_flush", 64);
        chk("def_busy", int'(BUSY), 0);
        pulse(64);
        idle(70);

        ld(1);
        chk("d1_cur", int'(CUR_DLY), 1);
        chk("d1_a", int'(SRL_A), 0);
        chk("d1_stg", int'(STG_SEL), 0);
        chk("d1_vld", int'(VLD), 0);
        wait_vld("d1_flush", 1);
        pulse(1);
        idle(4);

        ld(0);
        chk("d0_cur", int'(CUR_DLY), 1);
        chk("d0_a", int'(SRL_A), 0);
        chk("d0_stg", int'(STG_SEL), 0);
        wait_vld("d0_flush", 1);
        pulse(1);
        idle(4);

        ld(200);
        chk("d200_cur", int'(CUR_DLY), 128);
        chk("d200_a", int'(SRL_A), 15);
        chk("d200_stg", int'(STG_SEL), 7);
        wait_vld("d200_flush", 128);
        pulse(128);
        idle(135);

        // Stale ones in the chain must never reach DOUT after the reload.
        DIN = 1'b1;
        idle(40);
        DIN = 1'b0;
        ld(17);
        chk("d17_cur", int'(CUR_DLY), 17);
        chk("d17_a", int'(SRL_A), 0);
        chk("d17_stg", int'(STG_SEL), 1);
        wait_vld("d17_flush", 17);
        idle(20);
        pulse(17);
        idle(22);

        ld(10);
        idle(5);
        ld(10);
        wait_vld("ld_in_flush", 10);

        ld(3);
        idle(2);
        ld(3);
        chk("ld_at_term_busy", int'(BUSY), 1);
        wait_vld("ld_at_term", 3);

        ld(20);
        tot = 0;
        celow = 0;
        while (VLD !== 1'b1 && tot < 1000) begin
            if (tot == 4) PAUSE = 1'b1;
            if (tot == 14) PAUSE = 1'b0;
            #1;
            if (SRL_CE !== 1'b1) celow++;
            step();
            tot++;
        end
        chk("pause_flush_len", tot, 30);
        chk("pause_ce_low", celow, 10);
        pulse(20);
        idle(24);

        ld(33);
        wait_vld("d33_flush", 33);
        idle(3);
        RST = 1'b1;
        step();
        chk("mid_rst_cur", int'(CUR_DLY), 64);
        chk("mid_rst_a", int'(SRL_A), 15);
        chk("mid_rst_stg", int'(STG_SEL), 3);
        chk("mid_rst_ce", int'(SRL_CE), 0);
        RST = 1'b0;
        #1;
        chk("mid_rst_vld", int'(VLD), 0);
        chk("mid_rst_busy", int'(BUSY), 1);
        wait_vld("mid_rst_flush", 64);
        pulse(64);
        idle(70);

`ifdef SRLDC_DROP_CNT_EN
        PAUSE = 1'b1;
        DIN = 1'b1;
        idle(300);
        DIN = 1'b0;
        chk("drop_sat", int'(DROP_CNT), 255);
        ld(64);
        chk("drop_clr", int'(DROP_CNT), 0);
        PAUSE = 1'b0;
        wait_vld("drop_reflush", 64);
`endif

        idle(2);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/srl_dly_ctrl.md
Name: srl_dly_ctrl

Overview:
- Sequencer and configurator for a cascaded chain of NSTG 16-deep single-bit SRL delay stages.
- Each stage's Q15 feeds the next stage's input. Used for L1A/L1A-match programmable latency in the DMB control path.
- Loads a requested delay, converts it into stage-select and tap-address values, and flushes stale contents with zeros.
- Drives the chain clock-enable, masks the output until the pipeline holds only fresh data, and registers the selected tap as DOUT.

Parameters:
- NSTG, 8, number of cascaded 16-deep stages; maximum delay MAXD = NSTG*16.
- DW, 8, width of the delay request; must satisfy 2^DW > MAXD.
- DEF_DLY, 64, delay applied at reset (1..MAXD).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- DLY  in  DW  requested delay in clocks (DIN-to-tap).
- LD  in  1  one-cycle strobe; latch DLY and re-sequence.
- PAUSE  in  1  freeze chain: CE low, all counters hold.
- DIN  in  1  data bit to be delayed.
- SRL_O  in  NSTG  tap O output of each stage (all stages share SRL_A).
- SRL_I  out  1  data into stage 0.
- SRL_CE  out  1  clock enable to all stages.
- SRL_A  out  4  tap address to all stages.
- STG_SEL  out  clog2(NSTG)  stage whose O is selected.
- CUR_DLY  out  DW  delay currently in effect (after clamping).
- BUSY  out  1  high during FLUSH.
- VLD  out  1  DOUT valid.
- DOUT  out  1  registered delayed data.

Behaviour:
- Clamp rule: D = 1 if DLY==0; D = MAXD if DLY>MAXD; otherwise D = DLY. Clamping happens in the LD cycle.
- Decode: SRL_A = (D-1)[3:0]; STG_SEL = (D-1)>>4. Both are registered and change only on the cycle after LD (or after reset).
- Latency: DIN sampled at edge k appears at DOUT after edge k+D (total D+1 clocks) when PAUSE is low throughout.
- DOUT <= VLD & SRL_O[STG_SEL] on each edge where SRL_CE=1; it holds while PAUSE=1.
- States: FLUSH, RUN.
- RST (synchronous, wins over everything):
  - CUR_DLY=DEF_DLY (clamped), SRL_A and STG_SEL decoded from it.
  - State=FLUSH, flush counter=0, VLD=0, DOUT=0, BUSY=1, SRL_CE=0 in the reset cycle.
  - Reset mid-operation restarts the flush; stale SRL contents are never exposed.
- FLUSH:
  - SRL_I=0, SRL_CE=~PAUSE, VLD=0.
  - The counter increments on each enabled cycle. When it reaches CUR_DLY: go to RUN, VLD=1 on the next cycle, BUSY=0.
  - DIN is ignored (dropped).
- RUN: SRL_I=DIN, SRL_CE=~PAUSE, VLD=1.
- LD in RUN: latch the clamped D, clear the counter, go to FLUSH next cycle, VLD=0 from that cycle.
- LD in FLUSH: re-latch, restart the count from 0.
- LD coincident with PAUSE: the latch still occurs; the count does not advance until PAUSE falls.
- LD with unchanged DLY still flushes; there is no shortcut.
- LD and the flush-count terminal cycle coincide: LD wins; stay in FLUSH with count 0.
- Counter width: DW bits; it never wraps because the terminal value is ≤ MAXD < 2^DW.

Optional Feature:
- Macro SRLDC_DROP_CNT_EN.
- Defined:
  - Adds output DROP_CNT[7:0], an 8-bit saturating count (sticks at 255) of DIN=1 samples discarded during FLUSH or while PAUSE=1.
  - Cleared by RST and by LD. An LD coincident with a dropped DIN counts 0 for that cycle.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package srl_dly_pkg:
  - state enum {FLUSH, RUN};
  - function clamp_dly(DLY, MAXD);
  - localparam helpers for the STG_SEL width (clog2).
- Sub-module srl_dly_cnt: flush counter with enable, synchronous clear and terminal compare, instantiated once.
- The SRL chain itself is instantiated beside this block, not inside it.

Test Plan:
- Reset release, no LD, DEF_DLY=64, PAUSE=0:
  - BUSY high for 64 enabled cycles, then VLD=1.
  - A DIN pulse at cycle c appears on DOUT at c+65.
  - SRL_A=15, STG_SEL=3.
- LD with DLY=1 in RUN:
  - SRL_A=0, STG_SEL=0, flush of 1 cycle.
  - DIN pulse appears 2 clocks later. DLY=0 gives identical results.
- LD with DLY=200 (NSTG=8): CUR_DLY=128, SRL_A=15, STG_SEL=7, 128-cycle flush, 129-clock latency.
- Pre-fill the chain with a DIN=1 stream, then LD DLY=17:
  - DOUT stays 0 during flush and after VLD rises until fresh data arrives.
  - No stale 1 ever appears with VLD=1.
- PAUSE for 10 cycles mid-FLUSH (DLY=20):
  - VLD rises 30 cycles after LD.
  - SRL_CE low exactly 10 cycles; counter held.
- RST asserted mid-RUN at DLY=33: state returns to FLUSH with CUR_DLY=64, VLD=0 the next cycle. With SRLDC_DROP_CNT_EN, 300 dropped 1s give DROP_CNT=255.
